div_issue_queue: RTL and testbench
==================================

DIV_ISSUE_QUEUE -- requirements
Module: div_issue_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries, power of two, at least 2.
REQ-002 Macro `ROB_LEN: ROB size; RW = $clog2(`ROB_LEN) is the ROB index width.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 disp_valid  in  1 / disp_ready  out  1  dispatch handshake; an op is accepted when both are 1.
REQ-006 disp_funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 disp_rob_idx  in  RW / disp_rd  in  7  ROB index and destination physical register.
REQ-008 disp_rsN_tag  in  7, disp_rsN_rdy  in  1, disp_rsN_data  in  32 (N=1,2)  source tag, source-ready flag, and value (valid only when disp_rsN_rdy is 1).
REQ-009 cdb_valid  in  1, cdb_rd  in  7, cdb_data  in  32  single result-broadcast port.
REQ-010 mispredict  in  1, flush_mask  in  `ROB_LEN  per-ROB-index squash vector.
REQ-011 div_i_valid  out  1, div_i_ready  in  1  issue handshake to the divider; the op fires when both are 1.
REQ-012 div_funct3 out 3, div_rs1_data out 32, div_rs2_data out 32, div_rob_idx out RW, div_rd out 7  fields of the issued op.
REQ-013 occupancy  out  $clog2(DEPTH)+1  count of valid entries.

Function
REQ-014 Each entry SHALL hold: valid, funct3, rob_idx, rd, two operand records (tag, rdy, data), and an age rank.
REQ-015 disp_ready SHALL be 1 only when registered occupancy < DEPTH; a slot freed by a same-cycle issue does not raise disp_ready.
REQ-016 An accepted dispatch SHALL write the lowest-index free entry at the next edge.
REQ-017 Dispatch bypass: if cdb_valid and cdb_rd equals a dispatching tag whose rdy flag is 0, that operand SHALL be written with rdy=1 and data=cdb_data.
REQ-018 Wakeup: each valid entry operand with rdy=0 and tag==cdb_rd while cdb_valid SHALL set rdy=1 and capture cdb_data at the edge.
REQ-019 An entry is eligible when valid and both operands have rdy=1 in registered state; an entry woken at edge t becomes eligible in the cycle after t.
REQ-020 Select: among eligible entries, choose the oldest by dispatch order; at most one issue per cycle.
REQ-021 The div_* outputs SHALL be combinational from the selected entry; div_i_valid SHALL be 1 iff an eligible entry exists and it is not squashed per REQ-024.
REQ-022 While div_i_valid=1 and div_i_ready=0, the outputs SHALL stay stable unless an older entry becomes eligible or the selected entry is flushed.
REQ-023 On a fire (div_i_valid and div_i_ready both 1), the selected entry SHALL be invalidated at the edge and the age ranks of younger entries updated.
REQ-024 Flush: when mispredict=1, every valid entry with flush_mask[rob_idx]=1 SHALL be invalidated at the edge; div_i_valid SHALL be 0 if the selected entry's mask bit is 1; a same-cycle dispatch with flush_mask[disp_rob_idx]=1 SHALL be dropped.
REQ-025 Simultaneous dispatch, wakeup, issue and flush in one cycle SHALL all apply; occupancy_next = occupancy + accepted dispatch − fire − flushed entries.
REQ-026 A dispatch whose rsN_tag matches no producer SHALL remain waiting indefinitely; no timeout.

Reset
REQ-027 While rst=1 (asynchronous): all entries invalid, occupancy=0, disp_ready=1, div_i_valid=0, and all div_* data outputs 0.
REQ-028 Reset asserted mid-operation SHALL discard all entries immediately; the first dispatch after rst falls is accepted in the first cycle.

Verification
REQ-029 Dispatch DIV 100/7 with both rdy=1 and div_i_ready=1 -> div_i_valid=1 in the next cycle with rs1_data=100, rs2_data=7; occupancy returns 0 after the fire.
REQ-030 Dispatch four ops with rs2 waiting on tag 5 (DEPTH=4) -> occupancy=4, disp_ready=0; cdb_valid with cdb_rd=5 and cdb_data=3 -> the oldest op issues the cycle after the edge, then one op per cycle in dispatch order.
REQ-031 Hold div_i_ready=0 for 3 cycles with one eligible entry -> div_i_valid=1 with stable fields; raise div_i_ready -> one fire, then the entry is freed.
REQ-032 Queue holds rob_idx 2, 3, 4; mispredict with flush_mask bits 3 and 4 set -> occupancy=1 and only rob 2 issues; a dispatch of rob 4 in the flush cycle is dropped.
REQ-033 Same cycle: dispatch whose rs1 tag=9 with rdy=0, cdb_rd=9, cdb_data=0x80000000 -> the entry stores rdy=1 with that value and is eligible in the next cycle.
REQ-034 Assert rst with 3 entries valid -> occupancy=0 and div_i_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/div_issue_queue.sv
// Out-of-order issue queue in front of a single integer divider.
// Operands wake from one CDB port; the oldest ready entry issues, with age tracked by per-entry rank.
`timescale 1ns/1ps
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module div_issue_queue #(
    parameter int DEPTH = 4,
    localparam int RW = $clog2(`ROB_LEN),
    localparam int AW = $clog2(DEPTH),
    localparam int OW = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                disp_valid,
    output logic                disp_ready,
    input  logic [2:0]          disp_funct3,
    input  logic [RW-1:0]       disp_rob_idx,
    input  logic [6:0]          disp_rd,
    input  logic [6:0]          disp_rs1_tag,
    input  logic                disp_rs1_rdy,
    input  logic [31:0]         disp_rs1_data,
    input  logic [6:0]          disp_rs2_tag,
    input  logic                disp_rs2_rdy,
    input  logic [31:0]         disp_rs2_data,
    input  logic                cdb_valid,
    input  logic [6:0]          cdb_rd,
    input  logic [31:0]         cdb_data,
    input  logic                mispredict,
    input  logic [`ROB_LEN-1:0] flush_mask,
    output logic                div_i_valid,
    input  logic                div_i_ready,
    output logic [2:0]          div_funct3,
    output logic [31:0]         div_rs1_data,
    output logic [31:0]         div_rs2_data,
    output logic [RW-1:0]       div_rob_idx,
    output logic [6:0]          div_rd,
    output logic [OW-1:0]       occupancy
);

    logic [DEPTH-1:0] valid_reg;
    logic [2:0]       funct3_reg [DEPTH];
    logic [RW-1:0]    rob_reg    [DEPTH];
    logic [6:0]       rd_reg     [DEPTH];
    logic [6:0]       tag1_reg   [DEPTH];
    logic [6:0]       tag2_reg   [DEPTH];
    logic [DEPTH-1:0] rdy1_reg;
    logic [DEPTH-1:0] rdy2_reg;
    logic [31:0]      data1_reg  [DEPTH];
    logic [31:0]      data2_reg  [DEPTH];
    logic [AW-1:0]    rank_reg   [DEPTH];
    logic [OW-1:0]    occupancy_reg;

    logic [DEPTH-1:0] eligible;
    logic [DEPTH-1:0] flush_hit;
    logic [DEPTH-1:0] removed;
    logic             found;
    logic [AW-1:0]    sel_idx;
    logic [AW-1:0]    best_rank;
    logic             sel_squash;
    logic             fire;
    logic             free_found;
    logic [AW-1:0]    free_idx;
    logic             disp_write;
    logic [OW-1:0]    removed_cnt;
    logic [OW-1:0]    survivors;
    logic             bypass1_rdy;
    logic             bypass2_rdy;
    logic [31:0]      bypass1_data;
    logic [31:0]      bypass2_data;

    // Ranks are dense 0..occupancy-1 among valid entries, so the smallest eligible rank is the oldest.
    always_comb begin
        found     = 1'b0;
        sel_idx   = '0;
        best_rank = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && (!found || rank_reg[i] < best_rank)) begin
                found     = 1'b1;
                sel_idx   = AW'(i);
                best_rank = rank_reg[i];
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!valid_reg[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = AW'(i);
            end
        end
    end

    always_comb begin
        removed_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            removed_cnt = removed_cnt + OW'(removed[i]);
        end
    end

    assign sel_squash  = mispredict & flush_mask[rob_reg[sel_idx]];
    assign div_i_valid = found & ~sel_squash;
    assign fire        = div_i_valid & div_i_ready;

    assign div_funct3   = found ? funct3_reg[sel_idx] : '0;
    assign div_rs1_data = found ? data1_reg[sel_idx]  : '0;
    assign div_rs2_data = found ? data2_reg[sel_idx]  : '0;
    assign div_rob_idx  = found ? rob_reg[sel_idx]    : '0;
    assign div_rd       = found ? rd_reg[sel_idx]     : '0;

    assign occupancy  = occupancy_reg;
    assign disp_ready = (occupancy_reg < OW'(DEPTH));
    assign disp_write = disp_valid & disp_ready & ~(mispredict & flush_mask[disp_rob_idx]);
    assign survivors  = occupancy_reg - removed_cnt;

    assign bypass1_rdy  = disp_rs1_rdy | (cdb_valid & (cdb_rd == disp_rs1_tag));
    assign bypass2_rdy  = disp_rs2_rdy | (cdb_valid & (cdb_rd == disp_rs2_tag));
    assign bypass1_data = disp_rs1_rdy ? disp_rs1_data : cdb_data;
    assign bypass2_data = disp_rs2_rdy ? disp_rs2_data : cdb_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= survivors + OW'(disp_write);
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [AW-1:0] dec;
            logic          wake1;
            logic          wake2;

            assign eligible[gi]  = valid_reg[gi] & rdy1_reg[gi] & rdy2_reg[gi];
            assign flush_hit[gi] = valid_reg[gi] & mispredict & flush_mask[rob_reg[gi]];
            assign removed[gi]   = flush_hit[gi] | (fire && sel_idx == AW'(gi));
            assign wake1 = cdb_valid & ~rdy1_reg[gi] & (tag1_reg[gi] == cdb_rd);
            assign wake2 = cdb_valid & ~rdy2_reg[gi] & (tag2_reg[gi] == cdb_rd);

            // Each older entry leaving this cycle moves this entry one step closer to the head.
            always_comb begin
                dec = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (removed[k] && rank_reg[k] < rank_reg[gi]) begin
                        dec = dec + AW'(1);
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg[gi]  <= 1'b0;
                    funct3_reg[gi] <= '0;
                    rob_reg[gi]    <= '0;
                    rd_reg[gi]     <= '0;
                    tag1_reg[gi]   <= '0;
                    tag2_reg[gi]   <= '0;
                    rdy1_reg[gi]   <= 1'b0;
                    rdy2_reg[gi]   <= 1'b0;
                    data1_reg[gi]  <= '0;
                    data2_reg[gi]  <= '0;
                    rank_reg[gi]   <= '0;
                end else if (disp_write && free_idx == AW'(gi)) begin
                    valid_reg[gi]  <= 1'b1;
                    funct3_reg[gi] <= disp_funct3;
                    rob_reg[gi]    <= disp_rob_idx;
                    rd_reg[gi]     <= disp_rd;
                    tag1_reg[gi]   <= disp_rs1_tag;
                    tag2_reg[gi]   <= disp_rs2_tag;
                    rdy1_reg[gi]   <= bypass1_rdy;
                    rdy2_reg[gi]   <= bypass2_rdy;
                    data1_reg[gi]  <= bypass1_data;
                    data2_reg[gi]  <= bypass2_data;
                    rank_reg[gi]   <= AW'(survivors);
                end else if (removed[gi]) begin
                    valid_reg[gi] <= 1'b0;
                end else if (valid_reg[gi]) begin
                    rank_reg[gi] <= rank_reg[gi] - dec;
                    if (wake1) begin
                        rdy1_reg[gi]  <= 1'b1;
                        data1_reg[gi] <= cdb_data;
                    end
                    if (wake2) begin
                        rdy2_reg[gi]  <= 1'b1;
                        data2_reg[gi] <= cdb_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_div_issue_queue.sv
// Directed bench for div_issue_queue (DEPTH=4): dispatch/issue, wakeup order, stall, flush, bypass, async reset.
`timescale 1ns/1ps
`ifndef ROB_LEN
`define ROB_LEN 16
`endif

module tb_div_issue_queue;
    localparam int RW = $clog2(`ROB_LEN);

    logic                clk = 1'b0;
    logic                rst;
    logic                disp_valid;
    logic                disp_ready;
    logic [2:0]          disp_funct3;
    logic [RW-1:0]       disp_rob_idx;
    logic [6:0]          disp_rd;
    logic [6:0]          disp_rs1_tag;
    logic                disp_rs1_rdy;
    logic [31:0]         disp_rs1_data;
    logic [6:0]          disp_rs2_tag;
    logic                disp_rs2_rdy;
    logic [31:0]         disp_rs2_data;
    logic                cdb_valid;
    logic [6:0]          cdb_rd;
    logic [31:0]         cdb_data;
    logic                mispredict;
    logic [`ROB_LEN-1:0] flush_mask;
    logic                div_i_valid;
    logic                div_i_ready;
    logic [2:0]          div_funct3;
    logic [31:0]         div_rs1_data;
    logic [31:0]         div_rs2_data;
    logic [RW-1:0]       div_rob_idx;
    logic [6:0]          div_rd;
    logic [2:0]          occupancy;

    int total = 0;
    int bad   = 0;

    div_issue_queue #(.DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready),
        .disp_funct3(disp_funct3), .disp_rob_idx(disp_rob_idx), .disp_rd(disp_rd),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs1_data(disp_rs1_data),
        .disp_rs2_tag(disp_rs2_tag), .disp_rs2_rdy(disp_rs2_rdy), .disp_rs2_data(disp_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rd(cdb_rd), .cdb_data(cdb_data),
        .mispredict(mispredict), .flush_mask(flush_mask),
        .div_i_valid(div_i_valid), .div_i_ready(div_i_ready),
        .div_funct3(div_funct3), .div_rs1_data(div_rs1_data), .div_rs2_data(div_rs2_data),
        .div_rob_idx(div_rob_idx), .div_rd(div_rd), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [2:0] f3, input logic [RW-1:0] rob, input logic [6:0] rd,
                        input logic [6:0] t1, input logic r1, input logic [31:0] d1,
                        input logic [6:0] t2, input logic r2, input logic [31:0] d2);
        disp_valid    = 1'b1;
        disp_funct3   = f3;
        disp_rob_idx  = rob;
        disp_rd       = rd;
        disp_rs1_tag  = t1;
        disp_rs1_rdy  = r1;
        disp_rs1_data = d1;
        disp_rs2_tag  = t2;
        disp_rs2_rdy  = r2;
        disp_rs2_data = d2;
    endtask

    task automatic idle();
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        mispredict = 1'b0;
        flush_mask = '0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        disp(3'b100, 4'd0, 7'd0, 7'd0, 1'b0, 32'd0, 7'd0, 1'b0, 32'd0);
        disp_valid  = 1'b0;
        cdb_rd      = 7'd0;
        cdb_data    = 32'd0;
        div_i_ready = 1'b0;
        #12;
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_div_valid", 32'(div_i_valid), 32'd0);
        chk("rst_div_rs1", div_rs1_data, 32'd0);
        rst = 1'b0;
        tick();

        // Single DIV 100/7
        div_i_ready = 1'b1;
        disp(3'b100, 4'd1, 7'd10, 7'd1, 1'b1, 32'd100, 7'd2, 1'b1, 32'd7);
        #1 chk("div_not_before_edge", 32'(div_i_valid), 32'd0);
        tick(); idle();
        chk("div_valid", 32'(div_i_valid), 32'd1);
        chk("div_rs1", div_rs1_data, 32'd100);
        chk("div_rs2", div_rs2_data, 32'd7);
        chk("div_funct3", 32'(div_funct3), 32'd4);
        chk("div_rd", 32'(div_rd), 32'd10);
        chk("div_occ1", 32'(occupancy), 32'd1);
        tick();
        chk("div_occ0", 32'(occupancy), 32'd0);
        chk("div_valid_after", 32'(div_i_valid), 32'd0);

        // Four ops waiting on tag 5
        for (int k = 0; k < 4; k++) begin
            disp(3'b101, RW'(8 + k), 7'(20 + k), 7'd0, 1'b1, 32'(1000 + k), 7'd5, 1'b0, 32'd0);
            tick();
        end
        idle();
        #1;
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_disp_ready", 32'(disp_ready), 32'd0);
        chk("full_no_issue", 32'(div_i_valid), 32'd0);
        cdb_valid = 1'b1; cdb_rd = 7'd5; cdb_data = 32'd3;
        #1 chk("wake_not_early", 32'(div_i_valid), 32'd0);
        tick(); idle();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("wake_valid_%0d", k), 32'(div_i_valid), 32'd1);
            chk($sformatf("wake_rd_%0d", k), 32'(div_rd), 32'(20 + k));
            chk($sformatf("wake_rs1_%0d", k), div_rs1_data, 32'(1000 + k));
            chk($sformatf("wake_rs2_%0d", k), div_rs2_data, 32'd3);
            tick();
        end
        chk("wake_occ0", 32'(occupancy), 32'd0);

        // Stall with div_i_ready low
        div_i_ready = 1'b0;
        disp(3'b111, 4'd6, 7'd33, 7'd0, 1'b1, 32'd50, 7'd0, 1'b1, 32'd8);
        tick(); idle();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall_valid_%0d", k), 32'(div_i_valid), 32'd1);
            chk($sformatf("stall_rs1_%0d", k), div_rs1_data, 32'd50);
            chk($sformatf("stall_f3_%0d", k), 32'(div_funct3), 32'd7);
            tick();
        end
        div_i_ready = 1'b1;
        #1 chk("stall_fire_valid", 32'(div_i_valid), 32'd1);
        tick();
        chk("stall_occ0", 32'(occupancy), 32'd0);
        chk("stall_valid0", 32'(div_i_valid), 32'd0);

        // Flush rob 3 and 4, drop a same-cycle dispatch of rob 4
        div_i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(3'b110, RW'(2 + k), 7'(42 + k), 7'd0, 1'b1, 32'd9, 7'd0, 1'b1, 32'd4);
            tick();
        end
        idle();
        #1 chk("flush_pre_occ", 32'(occupancy), 32'd3);
        mispredict = 1'b1;
        flush_mask = 16'h0018;
        disp(3'b110, 4'd4, 7'd45, 7'd0, 1'b1, 32'd9, 7'd0, 1'b1, 32'd4);
        #1 chk("flush_sel_kept", 32'(div_i_valid), 32'd1);
        tick(); idle();
        chk("flush_occ", 32'(occupancy), 32'd1);
        chk("flush_rob", 32'(div_rob_idx), 32'd2);
        div_i_ready = 1'b1;
        tick();
        chk("flush_occ0", 32'(occupancy), 32'd0);
        chk("flush_valid0", 32'(div_i_valid), 32'd0);

        // Flushing the selected entry squashes the issue
        div_i_ready = 1'b0;
        disp(3'b100, 4'd7, 7'd60, 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1);
        tick(); idle();
        mispredict = 1'b1;
        flush_mask = 16'h0080;
        #1 chk("squash_valid", 32'(div_i_valid), 32'd0);
        tick(); idle();
        chk("squash_occ0", 32'(occupancy), 32'd0);

        // Dispatch bypass from CDB
        div_i_ready = 1'b1;
        disp(3'b100, 4'd5, 7'd70, 7'd9, 1'b0, 32'd0, 7'd0, 1'b1, 32'd2);
        cdb_valid = 1'b1; cdb_rd = 7'd9; cdb_data = 32'h8000_0000;
        tick(); idle();
        chk("bypass_valid", 32'(div_i_valid), 32'd1);
        chk("bypass_rs1", div_rs1_data, 32'h8000_0000);
        tick();
        chk("bypass_occ0", 32'(occupancy), 32'd0);

        // Older entry waking overtakes a younger ready one
        div_i_ready = 1'b0;
        disp(3'b100, 4'd1, 7'd51, 7'd11, 1'b0, 32'd0, 7'd0, 1'b1, 32'd1);
        tick();
        disp(3'b100, 4'd2, 7'd52, 7'd0, 1'b1, 32'd5, 7'd0, 1'b1, 32'd1);
        tick();
        disp(3'b100, 4'd3, 7'd53, 7'd11, 1'b0, 32'd0, 7'd0, 1'b1, 32'd1);
        tick(); idle();
        chk("age_first_sel", 32'(div_rd), 32'd52);
        cdb_valid = 1'b1; cdb_rd = 7'd11; cdb_data = 32'd99;
        tick(); idle();
        chk("age_oldest_sel", 32'(div_rd), 32'd51);
        chk("age_oldest_rs1", div_rs1_data, 32'd99);
        div_i_ready = 1'b1;
        tick();
        chk("age_second", 32'(div_rd), 32'd52);
        tick();
        chk("age_third", 32'(div_rd), 32'd53);
        chk("age_third_rs1", div_rs1_data, 32'd99);
        tick();
        chk("age_occ0", 32'(occupancy), 32'd0);

        // Asynchronous reset mid-operation
        div_i_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            disp(3'b101, RW'(k), 7'(80 + k), 7'd0, 1'b1, 32'd1, 7'd0, 1'b1, 32'd1);
            tick();
        end
        idle();
        #1 chk("arst_pre_occ", 32'(occupancy), 32'd3);
        #1 rst = 1'b1;
        #1;
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_valid", 32'(div_i_valid), 32'd0);
        chk("arst_rd", 32'(div_rd), 32'd0);
        chk("arst_disp_ready", 32'(disp_ready), 32'd1);
        rst = 1'b0;
        disp(3'b100, 4'd9, 7'd90, 7'd0, 1'b1, 32'd12, 7'd0, 1'b1, 32'd3);
        #1 chk("arst_first_ready", 32'(disp_ready), 32'd1);
        tick(); idle();
        chk("arst_first_occ", 32'(occupancy), 32'd1);
        chk("arst_first_rd", 32'(div_rd), 32'd90);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
